// File: rtl/regbank_pkg.sv
// Shared constants and parameter checks for the reg_bank register section.
package regbank_pkg;

    // Default C-bus / B-bus codes of register 0 in the processor register map
    localparam int DEF_CBASE = 6;
    localparam int DEF_BBASE = 4;
    localparam int MAX_REGS  = 16;

    // True when codes base..base+n-1 all fit in a w-bit select field
    function automatic bit code_range_ok(input int base, input int n, input int w);
        return (base >= 0) && (n >= 1) && (n <= MAX_REGS) && (base + n <= (1 << w));
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// C-bus / B-bus / increment signal bundle for reg_bank.
interface reg_bank_if #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 4,
    parameter int CSEL_W   = 4,
    parameter int BSEL_W   = 3
);
    logic [WIDTH-1:0]    cbus_out;
    logic [CSEL_W-1:0]   cbus_en;
    logic [BSEL_W-1:0]   bbus_en;
    logic [NUM_REGS-1:0] inc_en;
    logic [WIDTH-1:0]    bbus_in;
    logic                bbus_hit;
    logic [NUM_REGS-1:0] wrap;

    modport master (
        output cbus_out, cbus_en, bbus_en, inc_en,
        input  bbus_in, bbus_hit, wrap
    );

    modport slave (
        input  cbus_out, cbus_en, bbus_en, inc_en,
        output bbus_in, bbus_hit, wrap
    );
endinterface

// File: rtl/regbank_cell.sv
// One datapath register with C-bus load, increment strobe and sticky wrap flag.
// State changes on the falling clock edge so the C-bus result can settle first.
module regbank_cell #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] INC_STEP = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic             inc,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);
    logic [WIDTH:0] sum;

    assign sum = {1'b0, q} + {1'b0, INC_STEP};

    // A write beats a same-cycle increment and also clears the wrap flag
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (wr) begin
            q    <= din;
            wrap <= 1'b0;
        end else if (inc) begin
            q <= sum[WIDTH-1:0];
            if (sum[WIDTH]) wrap <= 1'b1;
        end
    end
endmodule

// File: rtl/reg_bank.sv
// Bank of NUM_REGS datapath registers with C-bus write decode and B-bus read mux.
// Define REGBANK_BBUS_REG_EN to register the B-bus outputs on the rising edge.
module reg_bank
    import regbank_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NUM_REGS = 4,
    parameter int               CSEL_W   = 4,
    parameter int               BSEL_W   = 3,
    parameter int               CBASE    = DEF_CBASE,
    parameter int               BBASE    = DEF_BBASE,
    parameter logic [WIDTH-1:0] INC_STEP = 1
) (
    input  logic      clock,
    input  logic      reset,
    reg_bank_if.slave bus
);
    logic [NUM_REGS-1:0][WIDTH-1:0] q;
    logic [NUM_REGS-1:0]            wr;
    logic [NUM_REGS-1:0]            wrap_q;
    logic [WIDTH-1:0]               rd_data;
    logic                           rd_hit;

    if (!code_range_ok(CBASE, NUM_REGS, CSEL_W)) begin : g_bad_cbase
        $error("reg_bank: CBASE+NUM_REGS exceeds the cbus_en code space");
    end
    if (!code_range_ok(BBASE, NUM_REGS, BSEL_W)) begin : g_bad_bbase
        $error("reg_bank: BBASE+NUM_REGS exceeds the bbus_en code space");
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign wr[i] = (bus.cbus_en == CSEL_W'(CBASE + i));

        regbank_cell #(
            .WIDTH   (WIDTH),
            .INC_STEP(INC_STEP)
        ) u_cell (
            .clock(clock),
            .reset(reset),
            .wr   (wr[i]),
            .inc  (bus.inc_en[i]),
            .din  (bus.cbus_out),
            .q    (q[i]),
            .wrap (wrap_q[i])
        );
    end

    assign bus.wrap = wrap_q;

    // Unselected codes yield zero so the B-bus can be wired-OR with other sources
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!reset && bus.bbus_en == BSEL_W'(BBASE + i)) begin
                rd_hit  = 1'b1;
                rd_data = q[i];
            end
        end
    end

`ifdef REGBANK_BBUS_REG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.bbus_in  <= '0;
            bus.bbus_hit <= 1'b0;
        end else begin
            bus.bbus_in  <= rd_data;
            bus.bbus_hit <= rd_hit;
        end
    end
`else
    assign bus.bbus_in  = rd_data;
    assign bus.bbus_hit = rd_hit;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the register bank.
module tb_reg_bank;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] m_reg [4];
    logic [3:0]  m_wrap;

    reg_bank_if bus ();

    reg_bank dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic exp_hit(input logic [2:0] ben);
        return (ben >= 3'd4);
    endfunction

    function automatic logic [31:0] exp_data(input logic [2:0] ben);
        if (ben >= 3'd4) return m_reg[ben - 3'd4];
        return 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        m_wrap = 4'h0;
    endtask

    // Register i is written on code 6+i; otherwise an increment adds 1 mod 2^32
    task automatic model_edge(input logic [3:0] cen, input logic [31:0] d, input logic [3:0] inc);
        longint s;
        for (int i = 0; i < 4; i++) begin
            if (int'(cen) == 6 + i) begin
                m_reg[i]  = d;
                m_wrap[i] = 1'b0;
            end else if (inc[i]) begin
                s = longint'(m_reg[i]) + 1;
                if (s >= 64'h1_0000_0000) m_wrap[i] = 1'b1;
                m_reg[i] = s[31:0];
            end
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs settled in both modes
    task automatic step(input logic [3:0] cen, input logic [31:0] d, input logic [2:0] ben,
                        input logic [3:0] inc);
        bus.cbus_en  = cen;
        bus.cbus_out = d;
        bus.bbus_en  = ben;
        bus.inc_en   = inc;
        @(negedge clock);
        model_edge(cen, d, inc);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.cbus_en = 4'h0; bus.cbus_out = 32'h0; bus.bbus_en = 3'd4; bus.inc_en = 4'h0;
        model_clear();
        #1;
        tests++;
        if (bus.bbus_in !== 32'h0 || bus.bbus_hit !== 1'b0 || bus.wrap !== 4'h0) begin
            fails++;
            $display("FAIL reset_state got in=%h hit=%b wrap=%b want 0/0/0",
                     bus.bbus_in, bus.bbus_hit, bus.wrap);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int b = 0; b < 8; b++) begin
            step(4'h0, 32'h0, 3'(b), 4'h0);
            tests++;
            if (bus.bbus_in !== exp_data(3'(b)) || bus.bbus_hit !== exp_hit(3'(b))) begin
                fails++;
                $display("FAIL reset_read ben=%0d got %h/%b want %h/%b", b,
                         bus.bbus_in, bus.bbus_hit, exp_data(3'(b)), exp_hit(3'(b)));
            end
        end
    endtask

    task automatic test_write_readback();
        step(4'd7, 32'hDEADBEEF, 3'd5, 4'h0);
        tests++;
        if (bus.bbus_in !== 32'hDEADBEEF || bus.bbus_hit !== 1'b1) begin
            fails++;
            $display("FAIL write_readback got %h/%b want deadbeef/1", bus.bbus_in, bus.bbus_hit);
        end
        foreach (m_reg[i]) begin
            step(4'h0, 32'h0, 3'(4 + i), 4'h0);
            tests++;
            if (bus.bbus_in !== exp_data(3'(4 + i))) begin
                fails++;
                $display("FAIL others_untouched reg%0d got %h want %h", i, bus.bbus_in,
                         exp_data(3'(4 + i)));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want_v [3] = '{32'hFFFFFFFF, 32'h0, 32'h1};
        logic        want_w [3] = '{1'b0, 1'b1, 1'b1};
        step(4'd8, 32'hFFFFFFFE, 3'd6, 4'h0);
        for (int k = 0; k < 3; k++) begin
            step(4'h0, 32'h0, 3'd6, 4'b0100);
            tests++;
            if (bus.bbus_in !== want_v[k] || bus.wrap[2] !== want_w[k] || bus.wrap !== m_wrap) begin
                fails++;
                $display("FAIL wrap_step%0d got %h wrap=%b want %h wrap2=%b", k,
                         bus.bbus_in, bus.wrap, want_v[k], want_w[k]);
            end
        end
    endtask

    task automatic test_collision();
        // First give register 1 a sticky wrap so the collision must clear it
        step(4'd7, 32'hFFFFFFFF, 3'd5, 4'h0);
        step(4'h0, 32'h0, 3'd5, 4'b0010);
        step(4'd7, 32'd5, 3'd5, 4'h0);
        tests++;
        if (bus.bbus_in !== 32'd5 || bus.wrap[1] !== 1'b0) begin
            fails++;
            $display("FAIL write_clears_wrap got %h wrap=%b want 5 wrap1=0", bus.bbus_in, bus.wrap);
        end
        step(4'h0, 32'h0, 3'd5, 4'b0010);
        step(4'h0, 32'h0, 3'd5, 4'b0010);
        step(4'h0, 32'h0, 3'd5, 4'b0010);
        step(4'd7, 32'hFFFFFFFF, 3'd5, 4'h0);
        step(4'h0, 32'h0, 3'd5, 4'b0010);
        step(4'd7, 32'd100, 3'd5, 4'b0010);
        tests++;
        if (bus.bbus_in !== 32'd100 || bus.wrap[1] !== 1'b0) begin
            fails++;
            $display("FAIL collision got %h wrap=%b want 100 wrap1=0", bus.bbus_in, bus.wrap);
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] codes [2] = '{4'd0, 4'd10};
        foreach (codes[c]) begin
            step(codes[c], 32'h1234, 3'd0, 4'h0);
            tests++;
            if (bus.bbus_in !== 32'h0 || bus.bbus_hit !== 1'b0) begin
                fails++;
                $display("FAIL oor_read code=%0d got %h/%b want 0/0", codes[c], bus.bbus_in,
                         bus.bbus_hit);
            end
            for (int i = 0; i < 4; i++) begin
                step(4'h0, 32'h0, 3'(4 + i), 4'h0);
                tests++;
                if (bus.bbus_in !== exp_data(3'(4 + i))) begin
                    fails++;
                    $display("FAIL oor_nowrite code=%0d reg%0d got %h want %h", codes[c], i,
                             bus.bbus_in, exp_data(3'(4 + i)));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  cen;
        logic [31:0] d;
        logic [2:0]  ben;
        logic [3:0]  inc;
        for (int n = 0; n < 300; n++) begin
            cen = 4'($urandom_range(0, 15));
            d   = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 2) : $urandom;
            ben = 3'($urandom_range(0, 7));
            inc = 4'($urandom);
            step(cen, d, ben, inc);
            tests++;
            if (bus.bbus_in !== exp_data(ben) || bus.bbus_hit !== exp_hit(ben) || bus.wrap !== m_wrap) begin
                fails++;
                $display("FAIL random n=%0d ben=%0d got %h/%b/%b want %h/%b/%b", n, ben,
                         bus.bbus_in, bus.bbus_hit, bus.wrap, exp_data(ben), exp_hit(ben), m_wrap);
            end
        end
    endtask

    task automatic test_async_reset();
        step(4'd6, 32'h11, 3'd7, 4'h0);
        step(4'd9, 32'hFFFFFFFF, 3'd7, 4'h0);
        step(4'h0, 32'h0, 3'd7, 4'b1000);
        tests++;
        if (bus.wrap[3] !== 1'b1) begin
            fails++;
            $display("FAIL async_setup wrap=%b want wrap3=1", bus.wrap);
        end
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        tests++;
        if (bus.bbus_in !== 32'h0 || bus.bbus_hit !== 1'b0 || bus.wrap !== 4'h0) begin
            fails++;
            $display("FAIL async_reset got %h/%b/%b want 0/0/0", bus.bbus_in, bus.bbus_hit, bus.wrap);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(4'h0, 32'h0, 3'(4 + i), 4'h0);
            tests++;
            if (bus.bbus_in !== 32'h0 || bus.bbus_hit !== 1'b1) begin
                fails++;
                $display("FAIL async_cleared reg%0d got %h/%b want 0/1", i, bus.bbus_in, bus.bbus_hit);
            end
        end
        step(4'd6, 32'hA5A5A5A5, 3'd4, 4'h0);
        tests++;
        if (bus.bbus_in !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL first_write_after_reset got %h want a5a5a5a5", bus.bbus_in);
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_wrap();
        test_collision();
        test_out_of_range();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of general-purpose datapath registers for the down-sampling processor. Each register is loaded from the C-bus when its C-bus enable code is presented, and any one of them can be driven onto the B-bus by its B-bus enable code. Each register also carries a per-register increment strobe with a sticky wrap flag, so pointer and index registers can step through sample buffers without an ALU pass. The block replaces individual single-register instances in the register section.

## Interface
Parameters:
- WIDTH, 32: register and bus width.
- NUM_REGS, 4: number of registers, 1..16.
- CSEL_W, 4: width of cbus_en.
- BSEL_W, 3: width of bbus_en.
- CBASE, 6: C-bus code of register 0. Register i is written on code CBASE+i. Constraint: CBASE+NUM_REGS ≤ 2^CSEL_W.
- BBASE, 4: B-bus code of register 0. Register i is read on code BBASE+i. Constraint: BBASE+NUM_REGS ≤ 2^BSEL_W.
- INC_STEP, 1: increment amount, WIDTH bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cbus_out  in  WIDTH  C-bus data.
- cbus_en  in  CSEL_W  C-bus destination code.
- bbus_en  in  BSEL_W  B-bus source code.
- inc_en  in  NUM_REGS  per-register increment strobes.
- bbus_in  out  WIDTH  B-bus data from the selected register.
- bbus_hit  out  1  high when bbus_en selects a register in this bank.
- wrap  out  NUM_REGS  sticky per-register wrap flags.

## Operation
- Reset (asynchronous, active-high) forces:
  - every register to 0;
  - wrap to 0;
  - bbus_in to 0 and bbus_hit to 0 (both the combinational and the registered form).
- Write: when cbus_en == CBASE+i, register i ← cbus_out, and wrap[i] is cleared.
- Increment: when inc_en[i] is set and no write targets register i, register i ← (register i + INC_STEP) mod 2^WIDTH.
  - If the true sum is ≥ 2^WIDTH (carry out), wrap[i] is set.
  - Once set, wrap[i] stays set until reset or a write to register i.
- Simultaneous write and increment to the same register: the write wins, the increment is dropped, and wrap[i] is cleared.
- Multiple inc_en bits may be set in the same cycle. The affected registers update independently.
- Codes outside the decoded ranges are ignored: no write, bbus_hit = 0, bbus_in = 0.
- Read: bbus_in = register (bbus_en − BBASE) when bbus_hit, otherwise 0. This allows wired-OR bus merging with other sources.

## Timing
- Register writes, increments and wrap updates take effect on the negedge of clock, matching the datapath convention that the C-bus result settles in the first half-cycle.
- Without the registered-output option: bbus_in and bbus_hit are combinational from bbus_en and register contents. A value written at a negedge is visible on the B-bus from that negedge onward.
- With REGBANK_BBUS_REG_EN: see Configuration.
- Reset asserted mid-cycle clears all state immediately, with no clock edge required. The first write after deassertion is honoured at the next negedge.

## Configuration
- REGBANK_BBUS_REG_EN defined:
  - bbus_in and bbus_hit are registered on the posedge of clock from the selected register, giving one cycle of latency.
  - A non-matching code registers 0 and 0.
  - A write at negedge N appears on the B-bus at the following posedge if selected.
- REGBANK_BBUS_REG_EN undefined: the B-bus path is purely combinational, as in Timing.

## Structure
- Package regbank_pkg holds:
  - default CBASE/BBASE code constants for the processor's register map;
  - a function that checks the code range, used by elaboration-time assertions on the parameter constraints.
- One sub-module, regbank_cell:
  - a single WIDTH register with write, increment and sticky-wrap logic;
  - generated NUM_REGS times;
  - the top level holds the decoders and the B-bus mux/register.

## Test plan
All scenarios use defaults (WIDTH=32, NUM_REGS=4, CBASE=6, BBASE=4, INC_STEP=1).
1. Reset then read: assert reset, release, bbus_en=4..7 → bbus_in=0, bbus_hit=1. bbus_en=0 → bbus_in=0, bbus_hit=0.
2. Write and readback: cbus_en=7, cbus_out=0xDEADBEEF, negedge; bbus_en=5 → bbus_in=0xDEADBEEF (same half-cycle with macro off, next posedge with macro on). Registers 0, 2 and 3 remain 0.
3. Wrap: write 0xFFFFFFFE to register 2 (cbus_en=8). Pulse inc_en[2] twice → value 0xFFFFFFFF then 0x00000000, wrap[2]=1 after the second. One further increment → 1, wrap[2] stays 1.
4. Write-vs-increment collision: register 1 holds 5, with cbus_en=7, cbus_out=100 and inc_en[1]=1 on the same negedge → register 1=100, wrap[1]=0.
5. Async reset mid-operation: registers nonzero and wrap[3]=1; raise reset between edges → all registers, wrap and bbus_in read 0 immediately, before any clock edge.
6. Out-of-range codes: cbus_en=0 with cbus_out=0x1234 → no register changes. cbus_en=10 → no change.
